ex_muldiv_seq: RTL and testbench
================================

Name: ex_muldiv_seq

Overview:
- Iterative multiply/divide sequencer attached to the EX stage. It replaces single-cycle combinational multiplication with a multi-cycle shift-add multiplier and a restoring divider that share one accumulator datapath.
- It accepts one operation at a time from ID/EX.
- It stalls the front of the pipeline while computing, then presents the result for exactly one cycle so EX can retire it.
- It covers the full RV32M set, selected by funct3.

Parameters:
WIDTH, 32, operand/result width; the iteration counter is $clog2(WIDTH)+1 bits
FAST_DIV0, 1, when 1, divide-by-zero completes without iterating

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous, active-low reset; 0 clears all state
start  in  1  ID/EX holds a valid M-extension instruction this cycle
funct3  in  3  RV32M op: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU
opa  in  WIDTH  rs1 value (multiplicand/dividend)
opb  in  WIDTH  rs2 value (multiplier/divisor)
flush  in  1  branch-taken kill from EX; aborts any in-flight op
ex_stall  out  1  hold IF/ID/EX pipeline registers
done  out  1  one-cycle pulse; result valid this cycle
result  out  WIDTH  final value; held until the next accepted start

Behaviour:
- States: IDLE, CALC, FIX, DONE. Reset (rst=0) forces IDLE, result=0, done=0, counter=0, accumulators=0. ex_stall=0 under reset.
- IDLE:
  - start=1 and flush=0 latches funct3, opa and opb, then goes to CALC. This is the accept edge T.
  - start is ignored in every other state. Upstream holds start asserted because ex_stall is high.
- Sign handling:
  - MULH, DIV and REM treat both operands as signed. MULHSU treats opa as signed and opb as unsigned. The remaining ops are unsigned.
  - Operands are converted to magnitudes at accept. neg_q = sign(a) xor sign(b) for signed operands. neg_r = sign(a).
- CALC, multiply:
  - Each cycle, if the multiplier LSB is 1, add the multiplicand into the upper half of a 2*WIDTH product.
  - Then shift the product/multiplier right by 1.
- CALC, divide:
  - Each cycle, shift {rem, quot} left by 1 and trial-subtract the divisor.
  - If there is no borrow, keep the difference and set the quotient bit to 1.
- Iteration count: CALC runs exactly WIDTH cycles, with the counter running 0..WIDTH-1. Then it goes to FIX.
- FIX (1 cycle):
  - Apply negation: product by neg_q, quotient by neg_q, remainder by neg_r.
  - Select the result. MUL takes the low half. MULH/MULHSU/MULHU take the high half. DIV/DIVU take the quotient. REM/REMU take the remainder.
  - Register the result, then go to DONE.
- DONE (1 cycle): done=1 and ex_stall=0, then go to IDLE.
- Latency: done is high in cycle T+WIDTH+2, which is T+34 for WIDTH=32.
- ex_stall = (IDLE & start & ~flush) | CALC | FIX. It is combinational on start so the instruction is held in its accept cycle.
- Divide by zero (opb=0, div ops):
  - Quotient = all ones (DIV and DIVU). Remainder = opa unmodified (REM and REMU).
  - With FAST_DIV0=1: IDLE→FIX→DONE, so done is at T+2.
  - With FAST_DIV0=0: the full iteration runs and the result is identical.
- Overflow: DIV 0x80000000 / 0xFFFFFFFF gives quotient 0x80000000 and remainder 0. The normal magnitude path produces this; it is not a special case.
- flush=1:
  - In CALC or FIX, the next state is IDLE.
  - done is not asserted, and result keeps its previous value.
  - In IDLE, flush blocks accept.
  - In DONE, the result still completes, because the instruction is already retiring.
- Async reset mid-operation aborts immediately. The outputs take their reset values with no done pulse.
- Back-to-back: a new start may be accepted in the cycle after DONE, which is IDLE. There is no start in the DONE cycle itself, because ex_stall is low and the pipeline advances.

Test Plan:
- MULHU opa=0xFFFFFFFF, opb=0xFFFFFFFF at T → ex_stall high T..T+33; done at T+34 with result=0xFFFFFFFE. MUL with the same operands gives result=0x00000001.
- MUL opa=0xFFFFFFFD (-3), opb=7 → result=0xFFFFFFEB. MULH gives 0xFFFFFFFF. MULHSU opa=0xFFFFFFFF, opb=0xFFFFFFFF gives 0xFFFFFFFF.
- DIV opa=0xFFFFFFF9 (-7), opb=2 → result=0xFFFFFFFD. REM with the same operands gives 0xFFFFFFFF. DIV 0x80000000 / 0xFFFFFFFF gives 0x80000000, and REM gives 0.
- DIVU opa=5, opb=0 with FAST_DIV0=1 → done at T+2 with result=0xFFFFFFFF. REMU 5/0 gives result=5.
- DIV accepted, flush=1 at T+10 → IDLE at T+11, no done pulse, result unchanged. A new start at T+11 completes normally.
- rst=0 asserted at T+5 mid-CALC → done=0, result=0, ex_stall=0 immediately. After rst=1, MUL 6*7 gives 42 at T'+34.

Source files
------------

// File: rtl/ex_muldiv_seq.sv
// rtl/ex_muldiv_seq.sv - iterative RV32M multiply/divide sequencer for the EX stage
module ex_muldiv_seq #(
    parameter int WIDTH     = 32,
    parameter bit FAST_DIV0 = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [2:0]       funct3,
    input  logic [WIDTH-1:0] opa,
    input  logic [WIDTH-1:0] opb,
    input  logic             flush,
    output logic             ex_stall,
    output logic             done,
    output logic [WIDTH-1:0] result
);
    localparam int CW = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX, S_DONE} state_t;

    state_t             state;
    logic [2:0]         op;
    logic [2*WIDTH-1:0] acc;     // product for mul, {rem, quot} for div
    logic [WIDTH-1:0]   opnd;    // multiplicand or divisor magnitude
    logic               neg_q;
    logic               neg_r;
    logic [CW-1:0]      cnt;

    logic               is_mul, sgn_a, sgn_b, div0;
    logic [WIDTH-1:0]   a_mag, b_mag;

    always_comb begin
        is_mul = ~funct3[2];
        sgn_a  = opa[WIDTH-1] & (funct3 inside {3'd1, 3'd2, 3'd4, 3'd6});
        sgn_b  = opb[WIDTH-1] & (funct3 inside {3'd1, 3'd4, 3'd6});
        a_mag  = sgn_a ? -opa : opa;
        b_mag  = sgn_b ? -opb : opb;
        div0   = ~is_mul & (opb == '0);
    end

    logic [WIDTH:0]     add_sum, r_sh;
    logic [WIDTH-1:0]   diff;
    logic               borrow;
    logic [2*WIDTH-1:0] acc_mul, acc_div;

    always_comb begin
        add_sum = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, (acc[0] ? opnd : {WIDTH{1'b0}})};
        acc_mul = {add_sum, acc[WIDTH-1:1]};
        r_sh    = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
        borrow  = r_sh < {1'b0, opnd};
        // A successful trial difference is always below the divisor, so W bits suffice
        diff    = r_sh[WIDTH-1:0] - opnd;
        acc_div = borrow ? {r_sh[WIDTH-1:0], acc[WIDTH-2:0], 1'b0}
                         : {diff, acc[WIDTH-2:0], 1'b1};
    end

    logic [2*WIDTH-1:0] prod;
    logic [WIDTH-1:0]   quo, rem, fix_res;

    always_comb begin
        prod = neg_q ? -acc : acc;
        quo  = neg_q ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
        rem  = neg_r ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
        case (op)
            3'd0:                fix_res = prod[WIDTH-1:0];
            3'd1, 3'd2, 3'd3:    fix_res = prod[2*WIDTH-1:WIDTH];
            3'd4, 3'd5:          fix_res = quo;
            default:             fix_res = rem;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state  <= S_IDLE;
            op     <= '0;
            acc    <= '0;
            opnd   <= '0;
            neg_q  <= 1'b0;
            neg_r  <= 1'b0;
            cnt    <= '0;
            result <= '0;
            done   <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start && !flush) begin
                        op    <= funct3;
                        opnd  <= is_mul ? a_mag : b_mag;
                        // Divide-by-zero: quotient all ones, remainder is the dividend
                        neg_q <= (sgn_a ^ sgn_b) & ~div0;
                        neg_r <= sgn_a;
                        cnt   <= '0;
                        if (FAST_DIV0 && div0) begin
                            acc   <= {a_mag, {WIDTH{1'b1}}};
                            state <= S_FIX;
                        end else begin
                            acc   <= {{WIDTH{1'b0}}, (is_mul ? b_mag : a_mag)};
                            state <= S_CALC;
                        end
                    end
                end
                S_CALC: begin
                    if (flush) begin
                        state <= S_IDLE;
                    end else begin
                        acc <= op[2] ? acc_div : acc_mul;
                        cnt <= cnt + 1'b1;
                        if (cnt == CW'(WIDTH - 1)) state <= S_FIX;
                    end
                end
                S_FIX: begin
                    if (flush) begin
                        state <= S_IDLE;
                    end else begin
                        result <= fix_res;
                        done   <= 1'b1;
                        state  <= S_DONE;
                    end
                end
                S_DONE:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

    assign ex_stall = rst & (((state == S_IDLE) & start & ~flush)
                             | (state == S_CALC) | (state == S_FIX));
endmodule

// File: tb/tb_ex_muldiv_seq.sv
// tb/tb_ex_muldiv_seq.sv - self-checking bench for ex_muldiv_seq
module tb_ex_muldiv_seq;
    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [2:0]  funct3;
    logic [31:0] opa, opb;
    logic        flush;
    logic        ex_stall, done;
    logic [31:0] result;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [31:0] prev_res = 32'h0;

    ex_muldiv_seq #(.WIDTH(32), .FAST_DIV0(1'b1)) dut (
        .clk(clk), .rst(rst), .start(start), .funct3(funct3), .opa(opa), .opb(opb),
        .flush(flush), .ex_stall(ex_stall), .done(done), .result(result)
    );

    always #5 clk = ~clk;

    task automatic chk(input logic [31:0] obs, input logic [31:0] exp, input string tag);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] ref_model(input logic [2:0] f3, input logic [31:0] a,
                                              input logic [31:0] b);
        longint      sa, sb, ua, ub;
        logic [63:0] p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = longint'({32'h0, a});
        ub = longint'({32'h0, b});
        case (f3)
            3'd0: begin p = ua * ub; return p[31:0];  end
            3'd1: begin p = sa * sb; return p[63:32]; end
            3'd2: begin p = sa * ub; return p[63:32]; end
            3'd3: begin p = ua * ub; return p[63:32]; end
            3'd4: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
                p = sa / sb; return p[31:0];
            end
            3'd5: begin
                if (b == 0) return 32'hFFFF_FFFF;
                p = ua / ub; return p[31:0];
            end
            3'd6: begin
                if (b == 0) return a;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h0;
                p = sa % sb; return p[31:0];
            end
            default: begin
                if (b == 0) return a;
                p = ua % ub; return p[31:0];
            end
        endcase
    endfunction

    task automatic do_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                         input string tag);
        int          n;
        int          lat;
        bit          seen, stall_ok;
        logic [31:0] exp;
        exp = ref_model(f3, a, b);
        lat = (f3[2] && b == 0) ? 2 : 34;
        @(negedge clk);
        chk({31'h0, done}, 32'h0, {tag, "_done_idle"});
        chk(result, prev_res, {tag, "_result_held"});
        flush = 1'b0; start = 1'b1; funct3 = f3; opa = a; opb = b;
        #1;
        chk({31'h0, ex_stall}, 32'h1, {tag, "_stall_accept"});
        n = 0; seen = 0; stall_ok = 1;
        while (!seen && n < 60) begin
            @(negedge clk);
            n++;
            if (done) seen = 1;
            else if (!ex_stall) stall_ok = 0;
        end
        chk({31'h0, seen}, 32'h1, {tag, "_done_seen"});
        chk(n, lat, {tag, "_latency"});
        chk({31'h0, ex_stall}, 32'h0, {tag, "_stall_done"});
        chk({31'h0, stall_ok}, 32'h1, {tag, "_stall_held"});
        chk(result, exp, {tag, "_result"});
        start = 1'b0;
        prev_res = exp;
    endtask

    initial begin
        int          n;
        bit          no_done;
        logic [2:0]  rf;
        logic [31:0] ra, rb;

        rst = 1'b0; start = 1'b1; funct3 = 3'd0; opa = 32'h5; opb = 32'h7; flush = 1'b0;
        repeat (3) @(negedge clk);
        chk({31'h0, ex_stall}, 32'h0, "reset_stall");
        chk({31'h0, done}, 32'h0, "reset_done");
        chk(result, 32'h0, "reset_result");
        start = 1'b0;
        rst = 1'b1;

        do_op(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "mulhu_max");
        do_op(3'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "mul_max");
        do_op(3'd0, 32'hFFFF_FFFD, 32'd7, "mul_neg");
        do_op(3'd1, 32'hFFFF_FFFD, 32'd7, "mulh_neg");
        do_op(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "mulhsu");
        do_op(3'd4, 32'hFFFF_FFF9, 32'd2, "div_neg");
        do_op(3'd6, 32'hFFFF_FFF9, 32'd2, "rem_neg");
        do_op(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, "div_ovf");
        do_op(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, "rem_ovf");
        do_op(3'd5, 32'd5, 32'd0, "divu_zero");
        do_op(3'd7, 32'd5, 32'd0, "remu_zero");
        do_op(3'd4, 32'hFFFF_FFF6, 32'd0, "div_zero_neg");
        do_op(3'd6, 32'hFFFF_FFF6, 32'd0, "rem_zero_neg");

        // flush in IDLE blocks accept
        @(negedge clk);
        start = 1'b1; funct3 = 3'd0; opa = 32'd3; opb = 32'd3; flush = 1'b1;
        #1;
        chk({31'h0, ex_stall}, 32'h0, "flush_idle_stall");
        @(negedge clk);
        chk({31'h0, ex_stall}, 32'h0, "flush_idle_not_accepted");
        start = 1'b0; flush = 1'b0;

        // flush mid-CALC: no done, result kept, next op accepted the following cycle
        @(negedge clk);
        start = 1'b1; funct3 = 3'd4; opa = 32'd100; opb = 32'd7;
        no_done = 1;
        for (int i = 1; i <= 10; i++) begin
            @(negedge clk);
            if (done) no_done = 0;
        end
        flush = 1'b1;
        chk({31'h0, no_done}, 32'h1, "flush_no_done");
        do_op(3'd5, 32'd1000, 32'd9, "after_flush");

        // async reset mid-CALC
        @(negedge clk);
        start = 1'b1; funct3 = 3'd0; opa = 32'd12345; opb = 32'd678;
        repeat (5) @(negedge clk);
        rst = 1'b0;
        #1;
        chk({31'h0, done}, 32'h0, "midrst_done");
        chk(result, 32'h0, "midrst_result");
        chk({31'h0, ex_stall}, 32'h0, "midrst_stall");
        @(negedge clk);
        rst = 1'b1; start = 1'b0;
        prev_res = 32'h0;
        do_op(3'd0, 32'd6, 32'd7, "mul_after_rst");

        for (int k = 0; k < 40; k++) begin
            rf = 3'($urandom_range(0, 7));
            ra = $urandom;
            rb = $urandom;
            case ($urandom_range(0, 5))
                0: rb = 32'h0;
                1: rb = 32'($urandom_range(1, 15));
                2: ra = 32'h8000_0000;
                default: ;
            endcase
            do_op(rf, ra, rb, "random");
        end

        n = 0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
